// File: rtl/csr_reg.sv
// Machine-mode CSR file with decode/execute and interrupt-controller ports plus a 64-bit cycle
// counter. Define CSR_INSTRET_EN to add the minstret counter at 0xB02/0xB82.
module csr_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] raddr_i,
    output logic [31:0] rdata_o,
    input  logic        we_i,
    input  logic [31:0] waddr_i,
    input  logic [31:0] wdata_i,
    input  logic        clint_we_i,
    input  logic [31:0] clint_raddr_i,
    input  logic [31:0] clint_waddr_i,
    input  logic [31:0] clint_wdata_i,
    output logic [31:0] clint_rdata_o,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o,
    output logic [31:0] mstatus_o,
    output logic        global_int_en_o,
    input  logic        instret_inc_i
);

    localparam logic [31:0] AddrMstatus  = 32'h300;
    localparam logic [31:0] AddrMie      = 32'h304;
    localparam logic [31:0] AddrMtvec    = 32'h305;
    localparam logic [31:0] AddrMscratch = 32'h340;
    localparam logic [31:0] AddrMepc     = 32'h341;
    localparam logic [31:0] AddrMcause   = 32'h342;
    localparam logic [31:0] AddrMcycle   = 32'hB00;
    localparam logic [31:0] AddrMcycleh  = 32'hB80;
    localparam logic [31:0] AddrCycle    = 32'hC00;
    localparam logic [31:0] AddrCycleh   = 32'hC80;

    localparam int IdxMstatus  = 0;
    localparam int IdxMie      = 1;
    localparam int IdxMtvec    = 2;
    localparam int IdxMscratch = 3;
    localparam int IdxMepc     = 4;
    localparam int IdxMcause   = 5;
    localparam int IdxMcycle   = 6;
    localparam int IdxMcycleh  = 7;

`ifdef CSR_INSTRET_EN
    localparam logic [31:0] AddrMinstret  = 32'hB02;
    localparam logic [31:0] AddrMinstreth = 32'hB82;
    localparam logic [31:0] AddrInstret   = 32'hC02;
    localparam logic [31:0] AddrInstreth  = 32'hC82;
    localparam int IdxMinstret  = 8;
    localparam int IdxMinstreth = 9;
    localparam int NumWr        = 10;
    localparam logic [31:0] WrAddr [NumWr] = '{
        AddrMstatus, AddrMie, AddrMtvec, AddrMscratch, AddrMepc, AddrMcause,
        AddrMcycle, AddrMcycleh, AddrMinstret, AddrMinstreth
    };
`else
    localparam int NumWr = 8;
    localparam logic [31:0] WrAddr [NumWr] = '{
        AddrMstatus, AddrMie, AddrMtvec, AddrMscratch, AddrMepc, AddrMcause,
        AddrMcycle, AddrMcycleh
    };
`endif

    // Only the writable addresses; the 0xCxx aliases are deliberately absent.
    function automatic logic f_writable(input logic [31:0] a);
        f_writable = 1'b0;
        for (int i = 0; i < NumWr; i++) begin
            if (a == WrAddr[i]) f_writable = 1'b1;
        end
    endfunction

    function automatic logic [31:0] f_rmask(input logic [31:0] a, input logic [31:0] d);
        return (a == AddrMepc) ? {d[31:2], 2'b00} : d;
    endfunction

    function automatic logic [63:0] f_cnt_next(input logic [63:0] cur, input logic inc,
                                               input logic lo_we, input logic [31:0] lo_d,
                                               input logic hi_we, input logic [31:0] hi_d);
        if (lo_we || hi_we) begin
            return {hi_we ? hi_d : cur[63:32], lo_we ? lo_d : cur[31:0]};
        end
        return cur + 64'(inc);
    endfunction

    logic [31:0] r_mstatus;
    logic [31:0] r_mie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [63:0] r_mcycle;
    logic [63:0] w_mcycle_nxt;

    logic [NumWr-1:0] w_wen;
    logic [31:0]      w_wdat [NumWr];
    logic [31:0]      w_raddr [2];
    logic [31:0]      w_rreg [2];

    // Per-register write select; the execute port wins a same-register collision.
    always_comb begin
        for (int i = 0; i < NumWr; i++) begin
            w_wen[i]  = 1'b0;
            w_wdat[i] = '0;
            if (we_i && (waddr_i == WrAddr[i])) begin
                w_wen[i]  = 1'b1;
                w_wdat[i] = wdata_i;
            end else if (clint_we_i && (clint_waddr_i == WrAddr[i])) begin
                w_wen[i]  = 1'b1;
                w_wdat[i] = clint_wdata_i;
            end
        end
    end

    assign w_mcycle_nxt = f_cnt_next(r_mcycle, 1'b1,
                                     w_wen[IdxMcycle], w_wdat[IdxMcycle],
                                     w_wen[IdxMcycleh], w_wdat[IdxMcycleh]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mstatus  <= '0;
            r_mie      <= '0;
            r_mtvec    <= '0;
            r_mscratch <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
            r_mcycle   <= '0;
        end else begin
            if (w_wen[IdxMstatus])  r_mstatus  <= w_wdat[IdxMstatus];
            if (w_wen[IdxMie])      r_mie      <= w_wdat[IdxMie];
            if (w_wen[IdxMtvec])    r_mtvec    <= w_wdat[IdxMtvec];
            if (w_wen[IdxMscratch]) r_mscratch <= w_wdat[IdxMscratch];
            if (w_wen[IdxMepc])     r_mepc     <= {w_wdat[IdxMepc][31:2], 2'b00};
            if (w_wen[IdxMcause])   r_mcause   <= w_wdat[IdxMcause];
            r_mcycle <= w_mcycle_nxt;
        end
    end

`ifdef CSR_INSTRET_EN
    logic [63:0] r_minstret;
    logic [63:0] w_minstret_nxt;

    assign w_minstret_nxt = f_cnt_next(r_minstret, instret_inc_i,
                                       w_wen[IdxMinstret], w_wdat[IdxMinstret],
                                       w_wen[IdxMinstreth], w_wdat[IdxMinstreth]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_minstret <= '0;
        end else begin
            r_minstret <= w_minstret_nxt;
        end
    end
`else
    logic w_unused_instret;
    assign w_unused_instret = instret_inc_i;
`endif

    assign w_raddr[0] = raddr_i;
    assign w_raddr[1] = clint_raddr_i;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rreg[p] = '0;
            case (w_raddr[p])
                AddrMstatus:             w_rreg[p] = r_mstatus;
                AddrMie:                 w_rreg[p] = r_mie;
                AddrMtvec:               w_rreg[p] = r_mtvec;
                AddrMscratch:            w_rreg[p] = r_mscratch;
                AddrMepc:                w_rreg[p] = r_mepc;
                AddrMcause:              w_rreg[p] = r_mcause;
                AddrMcycle,  AddrCycle:  w_rreg[p] = r_mcycle[31:0];
                AddrMcycleh, AddrCycleh: w_rreg[p] = r_mcycle[63:32];
`ifdef CSR_INSTRET_EN
                AddrMinstret,  AddrInstret:  w_rreg[p] = r_minstret[31:0];
                AddrMinstreth, AddrInstreth: w_rreg[p] = r_minstret[63:32];
`endif
                default:                 w_rreg[p] = '0;
            endcase
        end
    end

    // Bypass pending writes so a same-cycle read sees the value about to commit.
    always_comb begin
        rdata_o       = '0;
        clint_rdata_o = '0;
        if (rst_n) begin
            if (we_i && (waddr_i == raddr_i) && f_writable(raddr_i)) begin
                rdata_o = f_rmask(raddr_i, wdata_i);
            end else begin
                rdata_o = w_rreg[0];
            end
            if (we_i && (waddr_i == clint_raddr_i) && f_writable(clint_raddr_i)) begin
                clint_rdata_o = f_rmask(clint_raddr_i, wdata_i);
            end else if (clint_we_i && (clint_waddr_i == clint_raddr_i) &&
                         f_writable(clint_raddr_i)) begin
                clint_rdata_o = f_rmask(clint_raddr_i, clint_wdata_i);
            end else begin
                clint_rdata_o = w_rreg[1];
            end
        end
    end

    assign mtvec_o         = r_mtvec;
    assign mepc_o          = r_mepc;
    assign mstatus_o       = r_mstatus;
    assign global_int_en_o = r_mstatus[3];

endmodule

// File: doc/csr_reg.md
CSR_REG -- requirements
Module: csr_reg

Interface
REQ-001 clk  input  1  core clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous active-low reset.
REQ-003 raddr_i  input  MemAddrBus  decode-stage CSR read address, zero-extended 12-bit CSR number.
REQ-004 rdata_o  output  RegBus  decode-stage CSR read data, combinational.
REQ-005 we_i  input  1  execute-stage write enable, WriteEnable-polarity.
REQ-006 waddr_i  input  MemAddrBus  execute-stage write address.
REQ-007 wdata_i  input  RegBus  execute-stage write data.
REQ-008 clint_we_i  input  1  interrupt-controller write enable.
REQ-009 clint_raddr_i / clint_waddr_i  input  MemAddrBus  interrupt-controller read and write addresses.
REQ-010 clint_wdata_i  input  RegBus  interrupt-controller write data.
REQ-011 clint_rdata_o  output  RegBus  interrupt-controller read data, combinational.
REQ-012 mtvec_o / mepc_o / mstatus_o  output  RegBus  live register values for the interrupt controller.
REQ-013 global_int_en_o  output  1  mstatus.MIE (bit 3).
REQ-014 instret_inc_i  input  1  one instruction retired this cycle (used only under CSR_INSTRET_EN).

Function
REQ-015 Registers implemented: mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mcycle 0xB00, mcycleh 0xB80; read-only aliases cycle 0xC00, cycleh 0xC80.
REQ-016 Address match uses all MemAddrBus bits; unmapped addresses read 0, writes to them are ignored with no side effect.
REQ-017 Writes commit at the rising edge following a cycle with the enable asserted; read ports are combinational, zero wait states.
REQ-018 Simultaneous execute and interrupt-controller writes to the same register: execute port wins; writes to different registers both commit.
REQ-019 Read bypass: when we_i is asserted and waddr_i equals raddr_i (mapped, writable), rdata_o returns wdata_i; same rule for clint_rdata_o against the winning writer.
REQ-020 mepc bits [1:0] are hard-wired 0 on write and read; all other implemented registers are full 32-bit read/write.
REQ-021 64-bit cycle counter increments by 1 every cycle out of reset; wraps from all-ones to 0 without flag.
REQ-022 Write to mcycle replaces bits [31:0] and write to mcycleh replaces bits [63:32]; the increment is suppressed in that cycle; the non-written half holds.
REQ-023 Writes to 0xC00/0xC80 are ignored.
REQ-024 global_int_en_o, mtvec_o, mepc_o, mstatus_o reflect registered state only; no bypass.

Reset
REQ-025 On rst_n low, all registers including the cycle counter clear to 0 immediately, independent of clk.
REQ-026 Writes presented in the cycle reset deasserts are ignored only if rst_n is still low at the edge; first counter increment occurs on the first edge with rst_n high.
REQ-027 Reset mid-operation discards any in-flight write; all outputs read 0 while rst_n is low.

Configuration
REQ-028 Macro CSR_INSTRET_EN: defined -> 64-bit minstret at 0xB02/0xB82 (read-only aliases instret 0xC02/0xC82), incremented on instret_inc_i, same write, suppression and wrap rules as mcycle; undefined -> those addresses are unmapped (read 0), instret_inc_i ignored.

Verification
REQ-029 Reset, release, idle 10 cycles, read 0xC00 -> 10 (plus or minus a fixed offset documented by bench), 0xC80 -> 0.
REQ-030 we_i=1 waddr 0x305 wdata 0x8000_0100 with raddr_i=0x305 same cycle -> rdata_o=0x8000_0100 combinationally; mtvec_o=0x8000_0100 after edge.
REQ-031 Same cycle we_i to 0x341 data 0x11, clint_we_i to 0x341 data 0x22 -> mepc=0x10; clint to 0x342 data 0x8000_0007 with ex to 0x341 -> both commit.
REQ-032 Write mcycle=0xFFFF_FFFF, mcycleh=0xFFFF_FFFF, wait 1 cycle -> reads 0x0/0x0 (wrap).
REQ-033 Write 0x300 data 0x8 -> global_int_en_o=1 next cycle; write 0xC00 or 0x123 -> no register changes, reads 0.
REQ-034 CSR_INSTRET_EN defined: pulse instret_inc_i 5 cycles -> 0xB02 reads 5; undefined -> 0xB02 reads 0.
